// File: rtl/priority_arbiter.sv
// N-channel request arbiter with selectable fixed-priority or round-robin selection.
// The grant is locked until ack, then re-arbitrated back-to-back.
module priority_arbiter #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    input  logic             ack,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             zero
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic [IDX_W-1:0] fix_idx_s;
    logic [IDX_W-1:0] rr_idx_s;
    logic [IDX_W:0]   rr_pos_s;
    logic             rr_found_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [N-1:0]     gnt_nxt_s;
    logic [IDX_W-1:0] gnt_idx_nxt_s;
    logic             valid_nxt_s;
    logic             any_req_s;

    assign any_req_s = |req;

    // Fixed priority: highest set index wins, so the last match in the upward scan is kept.
    always_comb begin
        fix_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx_s = i[IDX_W-1:0];
            end else begin
                fix_idx_s = fix_idx_s;
            end
        end
    end

    // Round-robin: scan upward from ptr with wrap at N, first requester wins.
    always_comb begin
        rr_idx_s   = '0;
        rr_found_s = 1'b0;
        rr_pos_s   = '0;
        for (int k = 0; k < N; k++) begin
            rr_pos_s = {1'b0, ptr_r} + k[IDX_W:0];
            if (rr_pos_s >= N_EXT) begin
                rr_pos_s = rr_pos_s - N_EXT;
            end else begin
                rr_pos_s = rr_pos_s;
            end
            if (!rr_found_s && req[rr_pos_s[IDX_W-1:0]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = rr_pos_s[IDX_W-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    assign win_idx_s = rr_mode ? rr_idx_s : fix_idx_s;

    // Next state and next register values; a grant is only ever changed on arbitration or release.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        gnt_nxt_s     = gnt;
        gnt_idx_nxt_s = gnt_idx;
        valid_nxt_s   = gnt_valid;
        case (state_r)
            IDLE, GRANT: begin
                if ((state_r == IDLE) || ack) begin
                    if (any_req_s) begin
                        state_nxt_s            = GRANT;
                        gnt_nxt_s              = '0;
                        gnt_nxt_s[win_idx_s]   = 1'b1;
                        gnt_idx_nxt_s          = win_idx_s;
                        valid_nxt_s            = 1'b1;
                        ptr_nxt_s              = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + 1'b1;
                    end else begin
                        state_nxt_s   = IDLE;
                        gnt_nxt_s     = '0;
                        gnt_idx_nxt_s = '0;
                        valid_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                gnt_nxt_s     = '0;
                gnt_idx_nxt_s = '0;
                valid_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs; reset drops any grant at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            zero      <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            gnt       <= gnt_nxt_s;
            gnt_idx   <= gnt_idx_nxt_s;
            gnt_valid <= valid_nxt_s;
            zero      <= ~valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed-vector bench for priority_arbiter (N=8) with hand-computed expected grants.
module tb_priority_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         rr_mode;
    logic         ack;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_valid;
    logic         zero;

    int n_checks;
    int n_fail;

    priority_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_mode   (rr_mode),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // idx < 0 means no grant expected
    task automatic expect_grant(input string tag, input int idx);
        logic [N-1:0] g;
        g = '0;
        if (idx >= 0) begin
            g[idx] = 1'b1;
            check({tag, ".gnt"}, 64'(gnt), 64'(g));
            check({tag, ".idx"}, 64'(gnt_idx), 64'(idx));
            check({tag, ".valid"}, 64'(gnt_valid), 64'd1);
            check({tag, ".zero"}, 64'(zero), 64'd0);
        end else begin
            check({tag, ".gnt"}, 64'(gnt), 64'd0);
            check({tag, ".idx"}, 64'(gnt_idx), 64'd0);
            check({tag, ".valid"}, 64'(gnt_valid), 64'd0);
            check({tag, ".zero"}, 64'(zero), 64'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_seq [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 8'h00;
        rr_mode  = 1'b0;
        ack      = 1'b0;
        #1;
        expect_grant("reset", -1);
        tick();
        expect_grant("reset_clk", -1);
        rst = 1'b0;

        tick();
        expect_grant("idle_noreq", -1);

        // Fixed priority, then grant lock
        req = 8'b0010_1100;
        tick();
        expect_grant("fixed", 5);
        req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_grant("lock", 5);
        end
        ack = 1'b1;
        tick();
        expect_grant("release", -1);
        tick();
        expect_grant("ack_idle", -1);
        ack = 1'b0;

        // Reset restores ptr to 0, then full rotation with no bubble
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rr_mode = 1'b1;
        req     = 8'hFF;
        tick();
        expect_grant("rr_first", rr_seq[0]);
        ack = 1'b1;
        for (int s = 1; s < 9; s++) begin
            tick();
            expect_grant($sformatf("rr_rot%0d", s), rr_seq[s]);
        end

        // Wrap: grant 6 sets ptr to 7
        req = 8'h40;
        tick();
        expect_grant("rr_six", 6);
        req = 8'b0000_0011;
        tick();
        expect_grant("rr_wrap", 0);
        tick();
        expect_grant("rr_wrap_next", 1);
        req = 8'h00;
        tick();
        expect_grant("rr_idle", -1);

        // Fixed re-win of previous grantee, then round-robin moves on
        ack     = 1'b0;
        rr_mode = 1'b0;
        req     = 8'h09;
        tick();
        expect_grant("fix_a", 3);
        ack = 1'b1;
        tick();
        expect_grant("fix_rewin", 3);
        rr_mode = 1'b1;
        tick();
        expect_grant("rr_noretake", 0);

        // Async reset mid-grant on idx 3
        req = 8'h08;
        tick();
        expect_grant("pre_rst", 3);
        ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_grant("async_rst", -1);
        #1;
        rst  = 1'b0;
        req  = 8'b1000_1000;
        tick();
        expect_grant("post_rst", 3);

        // Mode switch does not disturb a held grant
        ack = 1'b1;
        req = 8'h04;
        tick();
        expect_grant("rr_two", 2);
        ack     = 1'b0;
        rr_mode = 1'b0;
        req     = 8'b0100_0100;
        tick();
        expect_grant("mode_hold", 2);
        tick();
        expect_grant("mode_hold2", 2);
        ack = 1'b1;
        tick();
        expect_grant("mode_switch", 6);
        req = 8'h00;
        tick();
        expect_grant("final_idle", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of request channels; legal range 2..64.
REQ-002 The block SHALL have localparam IDX_W, default $clog2(N), giving the width of the grant index.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  N  request vector; bit i set means channel i requests.
REQ-006 rr_mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-007 ack  input  1  current grantee finished; releases the grant.
REQ-008 gnt  output  N  registered one-hot grant vector; all-zero when nothing is granted.
REQ-009 gnt_idx  output  IDX_W  registered binary index of the granted channel.
REQ-010 gnt_valid  output  1  registered; 1 while a grant is held.
REQ-011 zero  output  1  registered; equals ~gnt_valid, meaning no grant is active.

Function
REQ-012 The FSM SHALL have two states, IDLE and GRANT, with reset state IDLE.
REQ-013 IDLE: if |req, the block SHALL pick a winner and enter GRANT; outputs show the grant on the next edge, so latency is 1 cycle from req to gnt.
REQ-014 IDLE: if req == 0, the block SHALL stay in IDLE with gnt=0, gnt_idx=0, gnt_valid=0 and zero=1.
REQ-015 Fixed mode: the winner SHALL be the highest set index of req (bit N-1 has highest priority).
REQ-016 Round-robin mode: the search SHALL start at pointer ptr and go upward with wrap from N-1 to 0; the first set bit wins.
REQ-017 ptr SHALL be IDX_W bits wide and reset to 0.
REQ-018 On each new grant to channel i, in either mode, ptr SHALL load (i+1) mod N; the wrap must be correct for non-power-of-two N.
REQ-019 GRANT with ack=0: gnt, gnt_idx and ptr SHALL hold, even if the grantee drops its req (the grant is locked until ack).
REQ-020 GRANT with ack=1 and req != 0: the block SHALL re-arbitrate in the same cycle and grant the new winner on the next edge (back-to-back, no bubble).
REQ-021 In fixed mode, the previous grantee SHALL be able to win again under REQ-020; in round-robin mode it wins only if no other channel requests.
REQ-022 GRANT with ack=1 and req == 0: the block SHALL return to IDLE and clear the outputs on the next edge.
REQ-023 ack in IDLE SHALL be ignored.
REQ-024 A change of rr_mode SHALL take effect at the next arbitration only; it SHALL never alter a held grant.
REQ-025 The block SHALL maintain these invariants every cycle:
- gnt is one-hot or zero;
- gnt[gnt_idx] == gnt_valid;
- zero == ~gnt_valid.

Reset
REQ-026 While rst=1, asynchronously and regardless of clk: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, zero=1, ptr=0.
REQ-027 rst asserted mid-grant SHALL drop the grant immediately, without waiting for ack.
REQ-028 rst SHALL take precedence over a simultaneous ack or req.
REQ-029 After rst deasserts, the first arbitration SHALL behave as from power-up (ptr=0).

Verification (N=8)
REQ-030 Fixed mode: rr_mode=0, req=8'b0010_1100 -> next cycle gnt=8'b0010_0000, gnt_idx=5, gnt_valid=1, zero=0.
REQ-031 Grant lock: after REQ-030, set req=0 with ack=0 for 3 cycles -> gnt holds 8'b0010_0000; then ack=1 -> next cycle gnt=0, zero=1.
REQ-032 Round-robin rotation: rr_mode=1, req=8'hFF held, ack=1 every GRANT cycle -> gnt_idx sequence 0,1,2,...,7,0, one grant per cycle with no bubble.
REQ-033 Round-robin wrap: rr_mode=1, ptr=7 (after a grant to 6), req=8'b0000_0011 -> gnt_idx=0; after ack, gnt_idx=1.
REQ-034 Async reset: during a grant on idx 3, pulse rst between clock edges -> gnt=0, gnt_valid=0, zero=1 before the next edge; then req=8'b1000_1000 with rr_mode=1 -> gnt_idx=3 (ptr=0).
REQ-035 Mode switch: grant held on idx 2 in round-robin mode, toggle rr_mode to 0 with ack=0 -> grant unchanged; on ack with req=8'b0100_0100 -> gnt_idx=6.
